fetch_sequencer: RTL and testbench

- Parametrised instruction fetch/sequencing unit; successor to the fixed-width PC, PC-logic and instruction-latch path.
- Owns the program counter and next-PC selection (increment, relative branch, absolute jump).
- Runs a memory-request handshake that tolerates variable wait states and holds the latched instruction for the control FSM.
- Adds single-step debug mode and a retired-instruction counter; sits between the control logic and the memory-management port A.

---
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing unit: owns the PC, runs the port-A read handshake,
// latches the instruction for the control FSM, and supports single-step debug.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       DISP_W   = 8,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  // memory port A
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  // control FSM interface
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch_take,
  input  logic [DISP_W-1:0]  branch_disp,
  input  logic               jump_take,
  input  logic [ADDR_W-1:0]  jump_addr,
  // debug
  input  logic               step_mode,
  input  logic               step,
  // status
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHold  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [ADDR_W-1:0]   disp_ext;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   pc_branch;
  logic [ADDR_W-1:0]   pc_target;

  // Next-PC candidates; all arithmetic wraps at the address width.
  always_comb begin
    disp_ext  = ADDR_W'($signed(branch_disp));
    pc_inc    = pc_q + ADDR_W'(1);
    pc_branch = pc_q + disp_ext;
    if (jump_take) begin
      pc_target = jump_addr;
    end else if (branch_take) begin
      pc_target = pc_branch;
    end else begin
      pc_target = pc_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          pc_d      = pc_target;
          retired_d = retired_q + CNT_W'(1);
          state_d   = step_mode ? StHold : StFetch;
        end
      end
      StHold: begin
        // A step pulse and dropping step_mode both release; together they still fetch once.
        if (step || !step_mode) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes decode from the state register, masked while reset is held.
  assign mem_req     = (state_q == StFetch) && !reset;
  assign instr_valid = (state_q == StExec) && !reset;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus1    = pc_inc;
  assign retired     = retired_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; a second instance with a 3-bit
// retired counter exercises counter wrap.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, mem_ready, exec_done, branch_take, jump_take, step_mode, step;
  logic [15:0] mem_rdata, jump_addr;
  logic [7:0]  branch_disp;

  logic        mem_req, instr_valid;
  logic [15:0] mem_addr, instr, pc, pc_plus1, retired;
  logic [1:0]  state;

  logic        s_mem_req, s_instr_valid;
  logic [15:0] s_mem_addr, s_instr, s_pc, s_pc_plus1;
  logic [2:0]  s_retired;
  logic [1:0]  s_state;

  int tests = 0;
  int fails = 0;

  fetch_sequencer #(
    .ADDR_W(16), .INSTR_W(16), .DISP_W(8), .CNT_W(16), .RESET_PC(16'h0000)
  ) u_dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .branch_take(branch_take), .branch_disp(branch_disp),
    .jump_take(jump_take), .jump_addr(jump_addr),
    .step_mode(step_mode), .step(step),
    .pc(pc), .pc_plus1(pc_plus1), .retired(retired), .state(state)
  );

  fetch_sequencer #(
    .ADDR_W(16), .INSTR_W(16), .DISP_W(8), .CNT_W(3), .RESET_PC(16'h0000)
  ) u_small (
    .clock(clock), .reset(reset),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(s_instr), .instr_valid(s_instr_valid), .exec_done(exec_done),
    .branch_take(branch_take), .branch_disp(branch_disp),
    .jump_take(jump_take), .jump_addr(jump_addr),
    .step_mode(step_mode), .step(step),
    .pc(s_pc), .pc_plus1(s_pc_plus1), .retired(s_retired), .state(s_state)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Completes the current instruction: waits (bounded) for EXEC, then retires it.
  task automatic run_instr(input logic jt, input logic [15:0] ja,
                           input logic bt, input logic [7:0] bd);
    int n = 0;
    mem_ready = 1'b1;
    while (state !== 2'd2 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (state !== 2'd2) begin
      fails++;
      $display("FAIL exec_wait: state %0d after %0d cycles, required 2", state, n);
    end
    jump_take   = jt;
    jump_addr   = ja;
    branch_take = bt;
    branch_disp = bd;
    exec_done   = 1'b1;
    tick();
    exec_done   = 1'b0;
    jump_take   = 1'b0;
    branch_take = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; exec_done = 1'b0; branch_take = 1'b0; jump_take = 1'b0;
    step_mode = 1'b0; step = 1'b0; mem_rdata = 16'h0; jump_addr = 16'h0; branch_disp = 8'h0;
    tick(); tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if (pc !== 16'h0) begin fails++; $display("FAIL reset_pc: got %h want 0000", pc); end
    tests++; if (instr !== 16'h0) begin fails++; $display("FAIL reset_instr: got %h want 0000", instr); end
    tests++; if (retired !== 16'h0) begin fails++; $display("FAIL reset_retired: got %0d want 0", retired); end
    tests++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: req %b valid %b want 0 0", mem_req, instr_valid);
    end
  endtask

  task automatic test_sequence();
    mem_ready = 1'b1;
    reset = 1'b0;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL seq_idle: got %0d want 0", state); end
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 16'h1000 + 16'(i);
      tests++; if (mem_req !== 1'b1 || mem_addr !== 16'(i)) begin
        fails++; $display("FAIL seq_fetch%0d: req %b addr %h want 1 %h", i, mem_req, mem_addr, 16'(i));
      end
      tick();
      tests++; if (instr !== 16'h1000 + 16'(i) || instr_valid !== 1'b1 || mem_req !== 1'b0) begin
        fails++; $display("FAIL seq_exec%0d: instr %h valid %b req %b want %h 1 0",
                          i, instr, instr_valid, mem_req, 16'h1000 + 16'(i));
      end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
    end
    tests++; if (retired !== 16'd3 || pc !== 16'd3) begin
      fails++; $display("FAIL seq_retired: retired %0d pc %h want 3 0003", retired, pc);
    end
  endtask

  task automatic test_wait_states();
    run_instr(1'b1, 16'h0005, 1'b0, 8'h00);
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || state !== 2'd1) begin
        fails++; $display("FAIL wait_hold%0d: req %b addr %h state %0d want 1 0005 1",
                          k, mem_req, mem_addr, state);
      end
      tick();
    end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin
      fails++; $display("FAIL wait_last: req %b addr %h want 1 0005", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    tests++; if (state !== 2'd2 || instr !== 16'hBEEF) begin
      fails++; $display("FAIL wait_latch: state %0d instr %h want 2 beef", state, instr);
    end
    mem_rdata = 16'h0000;
    tick();
    tests++; if (state !== 2'd2 || instr !== 16'hBEEF) begin
      fails++; $display("FAIL exec_stable: state %0d instr %h want 2 beef", state, instr);
    end
  endtask

  task automatic test_branch();
    run_instr(1'b1, 16'h0010, 1'b0, 8'h00);
    tests++; if (pc !== 16'h0010) begin fails++; $display("FAIL jump_10: got %h want 0010", pc); end
    run_instr(1'b0, 16'h0000, 1'b1, 8'hFE);
    tests++; if (pc !== 16'h000E) begin fails++; $display("FAIL branch_neg: got %h want 000e", pc); end
    run_instr(1'b1, 16'h0010, 1'b0, 8'h00);
    run_instr(1'b0, 16'h0000, 1'b1, 8'h7F);
    tests++; if (pc !== 16'h008F) begin fails++; $display("FAIL branch_pos: got %h want 008f", pc); end
    run_instr(1'b1, 16'h1234, 1'b1, 8'h7F);
    tests++; if (pc !== 16'h1234 || pc_plus1 !== 16'h1235) begin
      fails++; $display("FAIL jump_prio: pc %h plus1 %h want 1234 1235", pc, pc_plus1);
    end
  endtask

  task automatic test_pc_wrap();
    run_instr(1'b1, 16'hFFFF, 1'b0, 8'h00);
    tests++; if (pc !== 16'hFFFF || pc_plus1 !== 16'h0000 || mem_addr !== 16'hFFFF) begin
      fails++; $display("FAIL pc_max: pc %h plus1 %h addr %h want ffff 0000 ffff",
                        pc, pc_plus1, mem_addr);
    end
    run_instr(1'b0, 16'h0000, 1'b0, 8'h00);
    tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL pc_wrap: got %h want 0000", pc); end
  endtask

  task automatic test_retired_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) run_instr(1'b0, 16'h0000, 1'b0, 8'h00);
    tests++; if (s_retired !== 3'd7 || retired !== 16'd7) begin
      fails++; $display("FAIL retired_7: small %0d wide %0d want 7 7", s_retired, retired);
    end
    run_instr(1'b0, 16'h0000, 1'b0, 8'h00);
    tests++; if (s_retired !== 3'd0 || retired !== 16'd8) begin
      fails++; $display("FAIL retired_wrap: small %0d wide %0d want 0 8", s_retired, retired);
    end
  endtask

  task automatic test_step();
    step_mode = 1'b1;
    run_instr(1'b0, 16'h0000, 1'b0, 8'h00);
    tests++; if (state !== 2'd3 || pc !== 16'h0009) begin
      fails++; $display("FAIL step_hold: state %0d pc %h want 3 0009", state, pc);
    end
    exec_done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++; if (state !== 2'd3 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin
        fails++; $display("FAIL hold_idle%0d: state %0d req %b valid %b want 3 0 0",
                          k, state, mem_req, instr_valid);
      end
    end
    exec_done = 1'b0;
    tests++; if (pc !== 16'h0009 || retired !== 16'd9) begin
      fails++; $display("FAIL hold_ignore: pc %h retired %0d want 0009 9", pc, retired);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tests++; if (state !== 2'd1 || mem_req !== 1'b1) begin
      fails++; $display("FAIL step_fetch: state %0d req %b want 1 1", state, mem_req);
    end
    tick();
    tests++; if (state !== 2'd2 || instr_valid !== 1'b1) begin
      fails++; $display("FAIL step_exec: state %0d valid %b want 2 1", state, instr_valid);
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    tick();
    tests++; if (state !== 2'd3 || pc !== 16'h000A) begin
      fails++; $display("FAIL step_rehold: state %0d pc %h want 3 000a", state, pc);
    end
    step_mode = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL release_fetch: got %0d want 1", state); end
    tick();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL release_once: got %0d want 2", state); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    tick();
    tests++; if (state !== 2'd1 || pc !== 16'h000B) begin
      fails++; $display("FAIL pre_reset: state %0d pc %h want 1 000b", state, pc);
    end
    reset = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req_mask: got %b want 0", mem_req); end
    mem_ready = 1'b1;
    mem_rdata = 16'hCAFE;
    tick();
    tests++; if (state !== 2'd0 || pc !== 16'h0 || instr !== 16'h0 || mem_req !== 1'b0 ||
                 instr_valid !== 1'b0 || retired !== 16'h0) begin
      fails++; $display("FAIL reset_fetch: state %0d pc %h instr %h req %b valid %b ret %0d want 0 0 0 0 0 0",
                        state, pc, instr, mem_req, instr_valid, retired);
    end
    reset = 1'b0;
    tick();
    tests++; if (state !== 2'd1 || instr !== 16'h0) begin
      fails++; $display("FAIL late_ready: state %0d instr %h want 1 0000", state, instr);
    end
    tick();
    tests++; if (state !== 2'd2 || instr !== 16'hCAFE || pc !== 16'h0) begin
      fails++; $display("FAIL refetch: state %0d instr %h pc %h want 2 cafe 0000", state, instr, pc);
    end
    exec_done = 1'b1; jump_take = 1'b1; jump_addr = 16'h0055;
    reset = 1'b1;
    tick();
    exec_done = 1'b0; jump_take = 1'b0;
    tests++; if (state !== 2'd0 || pc !== 16'h0 || instr !== 16'h0 || instr_valid !== 1'b0 ||
                 retired !== 16'h0) begin
      fails++; $display("FAIL reset_exec: state %0d pc %h instr %h valid %b ret %0d want 0 0 0 0 0",
                        state, pc, instr, instr_valid, retired);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wait_states();
    test_branch();
    test_pc_wrap();
    test_retired_wrap();
    test_step();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
